// File: rtl/alu_issue_unit_if.sv
// Instruction handshake between an issuing master and the ALU issue unit.
interface alu_issue_unit_if #(
    parameter int AW = 2
);
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    instr_op;
    logic [AW-1:0] instr_rd;
    logic [AW-1:0] instr_rs1;
    logic [AW-1:0] instr_rs2;
    logic          instr_usec;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_usec,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_usec,
        output instr_ready
    );
endinterface

// File: rtl/alu_issue_unit.sv
// Three-phase issue sequencer for the 8-bit ALU: accept, register operands,
// then write the ALU result back and update the sticky {C,Z,S,V} flags.
module alu_issue_unit #(
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_issue_unit_if.slave     instr,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [7:0]          wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [7:0]          rd_data,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [2:0]          alu_op,
    output logic                alu_cin,
    input  logic [7:0]          alu_res,
    input  logic                alu_cout,
    input  logic                alu_zero,
    input  logic                alu_sign,
    input  logic                alu_ovf,
    output logic [3:0]          flags,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic          accept;

    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rs1_q;
    logic [AW-1:0] rs2_q;
    logic          usec_q;

    logic [7:0]    regs [NREG];
    logic          flag_c, flag_z, flag_s, flag_v;

    assign instr.instr_ready = (state == IDLE);
    assign accept            = instr.instr_valid && (state == IDLE);
    assign rd_data           = regs[rd_addr];
    assign flags             = {flag_c, flag_z, flag_s, flag_v};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = READ;
            READ:    state_nx = EXEC;
            EXEC:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            usec_q <= 1'b0;
        end else if (accept) begin
            op_q   <= instr.instr_op;
            rd_q   <= instr.instr_rd;
            rs1_q  <= instr.instr_rs1;
            rs2_q  <= instr.instr_rs2;
            usec_q <= instr.instr_usec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            alu_cin <= 1'b0;
        end else if (state == READ) begin
            alu_a   <= regs[rs1_q];
            alu_b   <= regs[rs2_q];
            alu_op  <= op_q;
            alu_cin <= usec_q & flag_c;
        end
    end

    // Writeback is assigned after the host write so it takes priority on an
    // address collision in the EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            if (state == EXEC) begin
                regs[rd_q] <= alu_res;
            end
        end
    end

    // Carry is only meaningful from add/sub; other ops leave C untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_s <= 1'b0;
            flag_v <= 1'b0;
        end else if (state == EXEC) begin
            flag_z <= alu_zero;
            flag_s <= alu_sign;
            flag_v <= alu_ovf;
            if (op_q == 3'b000 || op_q == 3'b001) begin
                flag_c <= alu_cout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (state == EXEC);
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit with a small behavioural ALU stand-in.
module tb_alu_issue_unit;

    localparam int NREG = 8;
    localparam int AW   = 3;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] stim_addr;
    logic [AW-1:0] mon_addr;
    logic          mon_sel;
    logic [7:0]    rd_data;
    logic [7:0]    alu_a, alu_b, alu_res;
    logic [2:0]    alu_op;
    logic          alu_cin, alu_cout, alu_zero, alu_sign, alu_ovf;
    logic [3:0]    flags;
    logic          done;
    logic [8:0]    t;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [AW-1:0] rd;
        logic [7:0]    res;
        logic [3:0]    fl;
        int            acc;
    } exp_t;
    exp_t sb[$];

    alu_issue_unit_if #(.AW(AW)) instr_if ();

    alu_issue_unit #(.NREG(NREG), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr_if),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_cin  (alu_cin),
        .alu_res  (alu_res),
        .alu_cout (alu_cout),
        .alu_zero (alu_zero),
        .alu_sign (alu_sign),
        .alu_ovf  (alu_ovf),
        .flags    (flags),
        .done     (done)
    );

    assign rd_addr = mon_sel ? mon_addr : stim_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU: add/sub define cout; logic ops drive cout low.
    always_comb begin
        t        = '0;
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (alu_op)
            3'b000: begin
                t        = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
                alu_res  = t[7:0];
                alu_cout = t[8];
                alu_ovf  = (alu_a[7] == alu_b[7]) && (alu_res[7] != alu_a[7]);
            end
            3'b001: begin
                t        = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
                alu_res  = t[7:0];
                alu_cout = t[8];
                alu_ovf  = (alu_a[7] != alu_b[7]) && (alu_res[7] != alu_a[7]);
            end
            3'b010:  alu_res = alu_a & alu_b;
            3'b011:  alu_res = alu_a | alu_b;
            3'b100:  alu_res = alu_a ^ alu_b;
            default: alu_res = alu_a;
        endcase
        alu_zero = (alu_res == 8'd0);
        alu_sign = alu_res[7];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        mon_sel  = 1'b0;
        mon_addr = '0;
        forever begin
            @(posedge clk);
            #2;
            if (done) begin
                check("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e        = sb.pop_front();
                    mon_addr = e.rd;
                    mon_sel  = 1'b1;
                    #1;
                    check("wb_data", 32'(rd_data), 32'(e.res));
                    check("flags", 32'(flags), 32'(e.fl));
                    check("latency", 32'(cyc - e.acc), 32'd2);
                    mon_sel = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic hw(input logic [AW-1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [AW-1:0] rd, rs1, rs2,
                        input logic usec, input logic [7:0] res, input logic [3:0] fl,
                        input bit keep, input bit push, output int waits, output int acc);
        bit ok;
        ok    = 1'b0;
        waits = 0;
        acc   = 0;
        instr_if.instr_op    = op;
        instr_if.instr_rd    = rd;
        instr_if.instr_rs1   = rs1;
        instr_if.instr_rs2   = rs2;
        instr_if.instr_usec  = usec;
        instr_if.instr_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (instr_if.instr_ready) begin
                @(posedge clk);
                @(negedge clk);
                acc = cyc;
                if (push) sb.push_back('{rd: rd, res: res, fl: fl, acc: acc});
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            waits++;
        end
        check("accept_in_time", 32'(ok), 32'd1);
        if (!keep) instr_if.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && instr_if.instr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_in_time", 32'(ok), 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_flags"}, 32'(flags), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ready"}, 32'(instr_if.instr_ready), 32'd1);
        check({tag, "_alu_ab"}, 32'({alu_a, alu_b}), 32'd0);
        check({tag, "_alu_opcin"}, 32'({alu_op, alu_cin}), 32'd0);
        for (int i = 0; i < NREG; i++) begin
            stim_addr = AW'(i);
            #1;
            check({tag, "_reg"}, 32'(rd_data), 32'd0);
        end
    endtask

    initial begin
        int w0, w1, w2, a0, a1, a2;
        rst_n                = 1'b0;
        wr_en                = 1'b0;
        wr_addr              = '0;
        wr_data              = '0;
        stim_addr            = '0;
        instr_if.instr_valid = 1'b0;
        instr_if.instr_op    = '0;
        instr_if.instr_rd    = '0;
        instr_if.instr_rs1   = '0;
        instr_if.instr_rs2   = '0;
        instr_if.instr_usec  = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 0x7F + 0x01: signed overflow into the sign bit
        hw(3'd1, 8'h7F);
        hw(3'd2, 8'h01);
        send(3'b000, 3'd3, 3'd1, 3'd2, 1'b0, 8'h80, 4'b0011, 1'b0, 1'b1, w0, a0);
        wait_idle();

        // Chained add: low byte sets C, high byte consumes it
        hw(3'd0, 8'hFF);
        hw(3'd1, 8'h01);
        send(3'b000, 3'd2, 3'd0, 3'd1, 1'b0, 8'h00, 4'b1100, 1'b0, 1'b1, w0, a0);
        wait_idle();
        hw(3'd3, 8'h00);
        hw(3'd4, 8'h00);
        send(3'b000, 3'd5, 3'd3, 3'd4, 1'b1, 8'h01, 4'b0000, 1'b0, 1'b1, w0, a0);
        wait_idle();

        // Carry retention across AND, then SUB updates C
        send(3'b000, 3'd2, 3'd0, 3'd1, 1'b0, 8'h00, 4'b1100, 1'b0, 1'b1, w0, a0);
        wait_idle();
        hw(3'd0, 8'hF0);
        hw(3'd1, 8'h0F);
        send(3'b010, 3'd6, 3'd0, 3'd1, 1'b0, 8'h00, 4'b1100, 1'b0, 1'b1, w0, a0);
        wait_idle();
        send(3'b001, 3'd7, 3'd0, 3'd1, 1'b0, 8'hE1, 4'b0010, 1'b0, 1'b1, w0, a0);
        wait_idle();

        // Back-to-back with valid held high; later ops read earlier results
        send(3'b011, 3'd4, 3'd0, 3'd1, 1'b0, 8'hFF, 4'b0010, 1'b1, 1'b1, w0, a0);
        send(3'b000, 3'd5, 3'd4, 3'd1, 1'b0, 8'h0E, 4'b1000, 1'b1, 1'b1, w1, a1);
        send(3'b000, 3'd6, 3'd5, 3'd5, 1'b1, 8'h1D, 4'b0000, 1'b0, 1'b1, w2, a2);
        check("b2b_gap1", 32'(a1 - a0), 32'd3);
        check("b2b_gap2", 32'(a2 - a1), 32'd3);
        check("b2b_notready1", 32'(w1), 32'd2);
        check("b2b_notready2", 32'(w2), 32'd2);
        wait_idle();

        // Collisions: host write to rs1 on READ edge, to rd on EXEC edge
        hw(3'd1, 8'h10);
        hw(3'd2, 8'h20);
        send(3'b000, 3'd1, 3'd1, 3'd2, 1'b0, 8'h30, 4'b0000, 1'b0, 1'b1, w0, a0);
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 8'h55;
        @(negedge clk);
        wr_data = 8'hAA;
        @(negedge clk);
        wr_en   = 1'b0;
        wait_idle();

        // Reset during EXEC aborts the instruction
        send(3'b000, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, w0, a0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        hw(3'd1, 8'h80);
        hw(3'd2, 8'h80);
        send(3'b000, 3'd0, 3'd1, 3'd2, 1'b0, 8'h00, 4'b1101, 1'b0, 1'b1, w0, a0);
        wait_idle();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequencer that sits directly upstream of the 8-bit ALU datapath and also receives its result.
- Accepts register-to-register instructions over a valid/ready handshake.
- Reads two operands from a small register file and drives the ALU's `a`, `b`, `opcode` and `cin` inputs from registers.
- Captures the ALU's `res`, `cout`, `zero`, `sign` and `overflow`, writes the result back to the destination register and maintains a sticky flag register.
- Lets a multi-byte add or subtract chain through the stored carry.

## Interface
Parameters:
- `NREG`, default 4: number of 8-bit registers; power of two, at least 2. `AW` = log2(`NREG`).

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  unit can accept; equals (state == IDLE).
- `instr_op`  in  3  ALU opcode, passed through unchanged.
- `instr_rd`, `instr_rs1`, `instr_rs2`  in  AW each  destination register, operand A source, operand B source.
- `instr_usec`  in  1  1 = drive `alu_cin` from the stored carry flag; 0 = drive `alu_cin` low.
- `wr_en`, `wr_addr` (AW), `wr_data` (8)  in  host register load port.
- `rd_addr`  in  AW  debug read address.
- `rd_data`  out  8  combinational read of `regs[rd_addr]`.
- `alu_a`, `alu_b`  out  8 each  registered operands to the ALU.
- `alu_op`  out  3  registered opcode to the ALU.
- `alu_cin`  out  1  registered carry-in to the ALU.
- `alu_res`  in  8  ALU result.
- `alu_cout`, `alu_zero`, `alu_sign`, `alu_ovf`  in  1 each  ALU status outputs.
- `flags`  out  4  {C, Z, S, V}, registered.
- `done`  out  1  one-cycle pulse when a writeback commits.

## Operation
State machine IDLE -> READ -> EXEC -> IDLE; no other states.

IDLE
- On `instr_valid` && `instr_ready`, capture op, rd, rs1, rs2 and usec into internal registers, then go to READ.
- Otherwise remain in IDLE.

READ
- `alu_a` <= `regs[rs1]`; `alu_b` <= `regs[rs2]`; `alu_op` <= captured op.
- `alu_cin` <= (usec ? C : 0).
- Go to EXEC.

EXEC
- The ALU is combinational, so its outputs are valid during this cycle.
- At the closing edge: `regs[rd]` <= `alu_res`; Z <= `alu_zero`; S <= `alu_sign`; V <= `alu_ovf`.
- C <= `alu_cout` only when op is 000 or 001. For all other ops C is retained, because the ALU does not define `cout` for them.
- `done` <= 1. Go to IDLE.

`done` is 0 in every other cycle.

Width rules:
- All data is 8-bit with no widening.
- Operand register reads use values as they stood before the READ edge.

Boundary conditions:
- rd equal to rs1 or rs2 is legal: operands were already latched in READ, so the writeback overwrites cleanly.
- Host write in any state is applied at that edge.
- Host write in the EXEC cycle to the same address as rd: writeback wins and the host write is dropped.
- Host write to rs1 or rs2 on the READ edge is not seen by the current instruction; the pre-edge value is used.
- `instr_valid` while not ready: ignored. Fields may change freely until accepted.
- Reset mid-instruction: the instruction is aborted with no writeback and no `done`.

Reset (`rst_n` low, asynchronous):
- state = IDLE.
- All `regs` = 0; `flags` = 0000.
- `alu_a`, `alu_b`, `alu_op`, `alu_cin` = 0.
- `done` = 0.
- `instr_ready` reads 1 during reset, but no accept occurs while `rst_n` is low.

## Timing
- Edge E0: instruction accepted; state -> READ; `instr_ready` drops.
- Edge E1: ALU inputs registered; state -> EXEC.
- Edge E2: writeback and flag update; `done` = 1 in the cycle after E2; `instr_ready` = 1 in that same cycle.
- Latency: 2 cycles from acceptance to `done`.
- Throughput: one instruction per 3 cycles; the next accept is possible in the cycle after E2 (the `done` cycle).
- `rd_data` reflects a writeback in the cycle after E2.
- `flags` change only at the E2 edge.

## Test plan
- Reset, then load r1=0x7F and r2=0x01 via the host port; issue op=000, rd=3, rs1=1, rs2=2 -> `done` exactly 2 cycles after accept; r3=0x80; flags C=0, Z=0, S=1, V=1.
- Chained add:
  - Load r0=0xFF, r1=0x01; issue op=000, rd=2 (r0+r1) -> r2=0x00, C=1, Z=1.
  - Then load r3=0x00, r4=0x00; issue op=000, rd=5, rs1=3, rs2=4, usec=1 -> r5=0x01, C=0, Z=0.
- Carry retention: with C=1, issue op=010 (AND) with r0=0xF0, r1=0x0F -> result 0x00, Z=1, C still 1.
- Back-to-back: hold `instr_valid` high with three instructions -> accepts occur exactly 3 cycles apart; `instr_ready` is low during READ and EXEC.
- Collision: during EXEC, host writes 0xAA to the same address as rd -> register holds the ALU result, not 0xAA. A host write to rs1 on the READ edge is not used by the current instruction.
- Assert `rst_n` low during EXEC -> no `done`, all registers 0, `flags`=0000; after release the first accept behaves normally.
